dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 52 +++++
 rtl/dmem_lane_align.sv | 34 +++
 rtl/dmem_ctrl.sv | 153 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the doubleword data-memory controller: access sizes, error codes,
// FSM states and the captured request control fields.
package dmem_pkg;

  localparam int unsigned DW     = 64;
  localparam int unsigned LANE_W = 3;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ALIGN = 2'd1,
    ERR_RANGE = 2'd2
  } err_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic  write;
    size_e size;
    logic  sgn;
  } req_ctrl_t;

  // Byte-lane mask of an access of the given size, anchored at lane 0.
  function automatic logic [7:0] size_mask(input size_e sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [LANE_W-1:0] lane);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return lane[0];
      SZ_W:    return |lane[1:0];
      default: return |lane;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: byte enables, store-data placement and load
// extraction with zero/sign extension (little-endian within the doubleword).
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e                   size,
  input  logic                    sgn,
  input  logic [LANE_W-1:0]       lane,
  input  logic [DW-1:0]           wdata,
  input  logic [DW-1:0]           rdword,
  output logic [7:0]              be_c,
  output logic [DW-1:0]           wdata_sh_c,
  output logic [DW-1:0]           rdata_c
);

  logic [5:0]    shamt_c;
  logic [DW-1:0] rd_sh_c;

  assign shamt_c    = {lane, 3'b000};
  assign be_c       = 8'(size_mask(size) << lane);
  assign wdata_sh_c = DW'(wdata << shamt_c);
  assign rd_sh_c    = DW'(rdword >> shamt_c);

  always_comb begin
    rdata_c = rd_sh_c;
    case (size)
      SZ_B: rdata_c = sgn ? {{56{rd_sh_c[7]}},  rd_sh_c[7:0]}  : {56'h0, rd_sh_c[7:0]};
      SZ_H: rdata_c = sgn ? {{48{rd_sh_c[15]}}, rd_sh_c[15:0]} : {48'h0, rd_sh_c[15:0]};
      SZ_W: rdata_c = sgn ? {{32{rd_sh_c[31]}}, rd_sh_c[31:0]} : {32'h0, rd_sh_c[31:0]};
      default: rdata_c = rd_sh_c;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressable doubleword data memory behind a valid/ready request/response FSM.
// Optional macro DMEM_PRELOAD_EN preloads doubleword k with nibble k[3:0] replicated.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  // Power-up image of the array; reset never touches it.
  function automatic logic [DEPTH-1:0][DATA_W-1:0] mem_init();
    logic [DEPTH-1:0][DATA_W-1:0] m;
    m = '0;
`ifdef DMEM_PRELOAD_EN
    for (int unsigned k = 0; k < DEPTH; k++) begin
      m[k] = {16{4'(k)}};
    end
`endif
    return m;
  endfunction

  logic [DEPTH-1:0][DATA_W-1:0] mem = mem_init();

  state_e            state_q, state_d;
  req_ctrl_t         ctrl_q, ctrl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  err_e              rsp_err_q, rsp_err_d;

  logic [LANE_W-1:0] lane_c;
  logic [IDX_W-1:0]  idx_c;
  logic              range_c;
  err_e              err_c;
  logic              mem_we_c;
  logic [DATA_W-1:0] rdword_c;
  logic [7:0]        be_c;
  logic [DATA_W-1:0] wdata_sh_c;
  logic [DATA_W-1:0] load_c;

  // Address decode and request checks on the captured request.
  assign lane_c   = addr_q[LANE_W-1:0];
  assign idx_c    = addr_q[IDX_W+2:3];
  assign range_c  = |addr_q[ADDR_W-1:IDX_W+3];
  assign err_c    = misaligned(ctrl_q.size, lane_c) ? ERR_ALIGN :
                    range_c                         ? ERR_RANGE : ERR_NONE;
  assign rdword_c = mem[idx_c];

  dmem_lane_align u_lane_align (
    .size       (ctrl_q.size),
    .sgn        (ctrl_q.sgn),
    .lane       (lane_c),
    .wdata      (wdata_q),
    .rdword     (rdword_c),
    .be_c       (be_c),
    .wdata_sh_c (wdata_sh_c),
    .rdata_c    (load_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ctrl_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          ctrl_d.write = req_write;
          ctrl_d.size  = size_e'(req_size);
          ctrl_d.sgn   = req_signed;
          addr_d       = req_addr;
          wdata_d      = req_wdata;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        rsp_err_d   = err_c;
        rsp_rdata_d = (err_c == ERR_NONE && !ctrl_q.write) ? load_c : '0;
        mem_we_c    = (err_c == ERR_NONE) && ctrl_q.write;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // Reset in the ACCESS cycle suppresses the write so an aborted store leaves no trace.
  always_ff @(posedge clk) begin
    if (!reset && mem_we_c) begin
      for (int b = 0; b < 8; b++) begin
        if (be_c[b]) mem[idx_c][b*8 +: 8] <= wdata_sh_c[b*8 +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl; expected data tracks DMEM_PRELOAD_EN when it is defined.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  function automatic logic [63:0] pre(input int k);
    logic [3:0] n;
    n = 4'(k);
`ifdef DMEM_PRELOAD_EN
    return {16{n}};
`else
    return (n == 4'd0) ? 64'h0 : 64'h0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [63:0] a, input logic [63:0] wd);
    int n;
    n = 0;
    while (!req_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid  = 1'b0;
  endtask

  // lat counts clock edges from driving req_valid to seeing rsp_valid.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [63:0] a, input logic [63:0] wd,
                        output logic [63:0] rd, output logic [1:0] er, output int lat);
    send(w, sz, sg, a, wd);
    wait_rsp(lat);
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] rd;
    logic [1:0]  er;
    logic [63:0] e;
    logic [63:0] held;
    int          lat;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Preloaded dword 2 and accept-to-response latency
    access(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, rd, er, lat);
    chk("ld_d_0x10_lat", 64'(lat), 64'd2);
    chk("ld_d_0x10", rd, pre(2));
    chk("ld_d_0x10_err", 64'(er), 64'd0);

    // Byte store into lane 3 of dword 1
    access(1'b1, 2'd0, 1'b0, 64'h0B, 64'hFFFF_FFFF_FFFF_FFA5, rd, er, lat);
    chk("st_b_0x0b_err", 64'(er), 64'd0);
    chk("st_b_0x0b_rdata", rd, 64'd0);
    e = pre(1);
    e[31:24] = 8'hA5;
    access(1'b0, 2'd3, 1'b0, 64'h08, 64'h0, rd, er, lat);
    chk("ld_d_0x08", rd, e);

    // Misaligned store must leave dword 1 untouched
    access(1'b1, 2'd2, 1'b0, 64'h0A, 64'h5555_5555, rd, er, lat);
    chk("st_w_0x0a_err", 64'(er), 64'd1);
    access(1'b0, 2'd3, 1'b0, 64'h08, 64'h0, rd, er, lat);
    chk("ld_d_0x08_after_misalign", rd, e);

    // Half store, signed and unsigned loads
    access(1'b1, 2'd1, 1'b0, 64'h20, 64'h0000_0000_0000_8001, rd, er, lat);
    chk("st_h_0x20_err", 64'(er), 64'd0);
    access(1'b0, 2'd1, 1'b1, 64'h20, 64'h0, rd, er, lat);
    chk("ld_hs_0x20", rd, 64'hFFFF_FFFF_FFFF_8001);
    access(1'b0, 2'd1, 1'b0, 64'h20, 64'h0, rd, er, lat);
    chk("ld_hu_0x20", rd, 64'h0000_0000_0000_8001);
    access(1'b0, 2'd0, 1'b1, 64'h21, 64'h0, rd, er, lat);
    chk("ld_bs_0x21", rd, 64'hFFFF_FFFF_FFFF_FF80);
    e = pre(4);
    e[15:0] = 16'h8001;
    access(1'b0, 2'd2, 1'b1, 64'h20, 64'h0, rd, er, lat);
    chk("ld_ws_0x20", rd, {32'h0, e[31:0]});

    // Full dword store and sub-dword extractions from it
    access(1'b1, 2'd3, 1'b0, 64'h30, 64'h0123_4567_89AB_CDEF, rd, er, lat);
    chk("st_d_0x30_err", 64'(er), 64'd0);
    access(1'b0, 2'd2, 1'b0, 64'h34, 64'h0, rd, er, lat);
    chk("ld_wu_0x34", rd, 64'h0000_0000_0123_4567);
    access(1'b0, 2'd0, 1'b1, 64'h33, 64'h0, rd, er, lat);
    chk("ld_bs_0x33", rd, 64'hFFFF_FFFF_FFFF_FF89);
    access(1'b0, 2'd1, 1'b0, 64'h36, 64'h0, rd, er, lat);
    chk("ld_hu_0x36", rd, 64'h0000_0000_0000_0123);
    access(1'b0, 2'd2, 1'b1, 64'h30, 64'h0, rd, er, lat);
    chk("ld_ws_0x30", rd, 64'hFFFF_FFFF_89AB_CDEF);
    access(1'b0, 2'd3, 1'b1, 64'h30, 64'h0, rd, er, lat);
    chk("ld_ds_0x30", rd, 64'h0123_4567_89AB_CDEF);

    // Error cases and range boundary
    access(1'b0, 2'd2, 1'b0, 64'h06, 64'h0, rd, er, lat);
    chk("ld_w_0x06_err", 64'(er), 64'd1);
    chk("ld_w_0x06_rdata", rd, 64'd0);
    access(1'b1, 2'd3, 1'b0, 64'h400, 64'hCAFE_F00D_CAFE_F00D, rd, er, lat);
    chk("st_d_0x400_err", 64'(er), 64'd2);
    chk("st_d_0x400_rdata", rd, 64'd0);
    access(1'b0, 2'd3, 1'b0, 64'h00, 64'h0, rd, er, lat);
    chk("ld_d_0x00_after_range", rd, pre(0));
    access(1'b0, 2'd1, 1'b0, 64'h401, 64'h0, rd, er, lat);
    chk("ld_h_0x401_err_prio", 64'(er), 64'd1);
    e = pre(127);
    access(1'b0, 2'd0, 1'b0, 64'h3FF, 64'h0, rd, er, lat);
    chk("ld_bu_0x3ff_err", 64'(er), 64'd0);
    chk("ld_bu_0x3ff", rd, {56'h0, e[63:56]});

    // Response back-pressure: held response, no new accept
    rsp_ready = 1'b0;
    send(1'b0, 2'd3, 1'b0, 64'h30, 64'h0);
    wait_rsp(lat);
    held = rsp_rdata;
    chk("stall_rdata", held, 64'h0123_4567_89AB_CDEF);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size  = 2'd3;
    req_addr  = 64'h08;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("stall_rdata_hold", rsp_rdata, 64'h0123_4567_89AB_CDEF);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("stall_release_req_ready", 64'(req_ready), 64'd1);

    // Reset during ACCESS aborts a dword store to 0x00
    send(1'b1, 2'd3, 1'b0, 64'h00, 64'h0000_0000_0000_DEAD);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    chk("abort_rsp_valid_later", 64'(rsp_valid), 64'd0);
    access(1'b0, 2'd3, 1'b0, 64'h00, 64'h0, rd, er, lat);
    chk("abort_readback_0x00", rd, pre(0));
    chk("abort_readback_lat", 64'(lat), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
